// File: rtl/uart_rx_deframer.sv
// UART receive deframer: 16x-oversampled start/data/parity/stop recovery,
// parity and framing checks, ready/ack handshake with sticky overrun.
module uart_rx_deframer #(
   parameter int unsigned DSIZE = 8,
   parameter int unsigned OSR   = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             sampleTick,
   input  logic             rxd,
   input  logic [3:0]       bitWidth,
   input  logic             parityEn,
   input  logic             parityOdd,
   input  logic             rxAck,
   output logic [DSIZE-1:0] dout,
   output logic             rxReady,
   output logic             parityErr,
   output logic             frameErr,
   output logic             overrun
);

   localparam int unsigned TW = $clog2(OSR);
   localparam logic [TW-1:0] HALF = TW'(OSR / 2 - 1);
   localparam logic [TW-1:0] FULL = TW'(OSR - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t           state, state_nxt;
   logic [TW-1:0]    tcnt, tcnt_nxt;
   logic             rx_meta, rxs;
   logic [2:0]       bit_idx;
   logic [2:0]       last_idx;
   logic [DSIZE-1:0] shreg;
   logic             par_acc, par_bit;
   logic             go_data, sample_data, sample_par, complete;

   // Widths outside 5..8 fall back to 8 data bits.
   always_comb begin
      if (bitWidth >= 4'd5 && bitWidth <= 4'd8) last_idx = 3'(bitWidth - 4'd1);
      else                                      last_idx = 3'd7;
   end

   always_comb begin
      state_nxt   = state;
      tcnt_nxt    = tcnt;
      go_data     = 1'b0;
      sample_data = 1'b0;
      sample_par  = 1'b0;
      complete    = 1'b0;
      if (sampleTick) begin
         case (state)
            IDLE: begin
               if (!rxs) begin
                  state_nxt = START;
                  tcnt_nxt  = '0;
               end
            end
            START: begin
               if (tcnt == HALF) begin
                  tcnt_nxt  = '0;
                  go_data   = ~rxs;
                  state_nxt = rxs ? IDLE : DATA;
               end else begin
                  tcnt_nxt = tcnt + 1'b1;
               end
            end
            DATA: begin
               if (tcnt == FULL) begin
                  tcnt_nxt    = '0;
                  sample_data = 1'b1;
                  if (bit_idx == last_idx) state_nxt = parityEn ? PARITY : STOP;
               end else begin
                  tcnt_nxt = tcnt + 1'b1;
               end
            end
            PARITY: begin
               if (tcnt == FULL) begin
                  tcnt_nxt   = '0;
                  sample_par = 1'b1;
                  state_nxt  = STOP;
               end else begin
                  tcnt_nxt = tcnt + 1'b1;
               end
            end
            STOP: begin
               // Leave at mid-stop so an immediately following start bit is seen.
               if (tcnt == FULL) begin
                  tcnt_nxt  = '0;
                  complete  = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  tcnt_nxt = tcnt + 1'b1;
               end
            end
            default: begin
               state_nxt = IDLE;
               tcnt_nxt  = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_meta   <= 1'b1;
         rxs       <= 1'b1;
         state     <= IDLE;
         tcnt      <= '0;
         bit_idx   <= '0;
         shreg     <= '0;
         par_acc   <= 1'b0;
         par_bit   <= 1'b0;
         dout      <= '0;
         rxReady   <= 1'b0;
         parityErr <= 1'b0;
         frameErr  <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         rx_meta <= rxd;
         rxs     <= rx_meta;
         state   <= state_nxt;
         tcnt    <= tcnt_nxt;
         if (go_data) begin
            bit_idx <= '0;
            shreg   <= '0;
            par_acc <= 1'b0;
         end
         if (sample_data) begin
            shreg[bit_idx] <= rxs;
            par_acc        <= par_acc ^ rxs;
            bit_idx        <= bit_idx + 3'd1;
         end
         if (sample_par) par_bit <= rxs;
         // Completion wins over a same-cycle ack; the ack then only cancels overrun.
         if (complete) begin
            dout      <= shreg;
            parityErr <= parityEn & (par_acc ^ par_bit ^ parityOdd);
            frameErr  <= ~rxs;
            rxReady   <= 1'b1;
            overrun   <= rxReady & ~rxAck;
         end else if (rxAck && rxReady) begin
            rxReady <= 1'b0;
            overrun <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed bench for uart_rx_deframer at OSR=16 with sampleTick on every clk.
module tb_uart_rx_deframer;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       sampleTick;
   logic       rxd;
   logic [3:0] bitWidth;
   logic       parityEn;
   logic       parityOdd;
   logic       rxAck;
   logic [7:0] dout;
   logic       rxReady, parityErr, frameErr, overrun;

   int checks = 0;
   int errors = 0;
   int rises  = 0;
   int rises_before;
   logic prev_ready = 1'b0;

   uart_rx_deframer #(.DSIZE(8), .OSR(16)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .sampleTick(sampleTick),
      .rxd       (rxd),
      .bitWidth  (bitWidth),
      .parityEn  (parityEn),
      .parityOdd (parityOdd),
      .rxAck     (rxAck),
      .dout      (dout),
      .rxReady   (rxReady),
      .parityErr (parityErr),
      .frameErr  (frameErr),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rxReady === 1'b1 && prev_ready !== 1'b1) rises++;
      prev_ready = rxReady;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic frame_bit(input logic [7:0] data, input int bw, input logic pe,
                                      input logic pbit, input logic stopb, input int k);
      if (k == 0) return 1'b0;
      if (k <= bw) return data[k-1];
      if (pe && k == bw + 1) return pbit;
      return stopb;
   endfunction

   // Bit k of the frame is driven for 16 clks; c counts clks from the start-bit drive.
   task automatic send_frame(input logic [7:0] data, input int bw, input logic pe,
                             input logic pbit, input logic stopb, input int gap, input int ack_at);
      int total;
      for (int g = 0; g < gap; g++) begin
         @(negedge clk);
         rxd   = 1'b1;
         rxAck = 1'b0;
      end
      total = (2 + bw + int'(pe)) * 16;
      for (int c = 0; c < total; c++) begin
         @(negedge clk);
         rxd   = frame_bit(data, bw, pe, pbit, stopb, c / 16);
         rxAck = (c == ack_at);
      end
      @(negedge clk);
      rxd   = 1'b1;
      rxAck = 1'b0;
   endtask

   task automatic pulse_ack();
      @(negedge clk);
      rxAck = 1'b1;
      @(negedge clk);
      rxAck = 1'b0;
   endtask

   initial begin
      reset_n    = 1'b0;
      sampleTick = 1'b1;
      rxd        = 1'b1;
      bitWidth   = 4'd8;
      parityEn   = 1'b0;
      parityOdd  = 1'b0;
      rxAck      = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_dout", 32'(dout), 32'h0);
      check("rst_ready", 32'(rxReady), 32'h0);
      check("rst_perr", 32'(parityErr), 32'h0);
      check("rst_ferr", 32'(frameErr), 32'h0);
      check("rst_ovr", 32'(overrun), 32'h0);
      reset_n = 1'b1;

      // 8N1 0xA5
      send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, 16, -1);
      check("a5_rises", 32'(rises), 32'd1);
      check("a5_dout", 32'(dout), 32'hA5);
      check("a5_perr", 32'(parityErr), 32'h0);
      check("a5_ferr", 32'(frameErr), 32'h0);
      check("a5_ready", 32'(rxReady), 32'h1);
      pulse_ack();
      check("a5_ack_ready", 32'(rxReady), 32'h0);
      check("a5_ack_dout", 32'(dout), 32'hA5);

      // 5-bit, parity: 0x15 has three ones
      bitWidth = 4'd5;
      parityEn = 1'b1;
      send_frame(8'h15, 5, 1'b1, 1'b1, 1'b1, 16, -1);
      check("p_even_ok_dout", 32'(dout), 32'h15);
      check("p_even_ok_perr", 32'(parityErr), 32'h0);
      pulse_ack();
      send_frame(8'h15, 5, 1'b1, 1'b0, 1'b1, 16, -1);
      check("p_even_bad_perr", 32'(parityErr), 32'h1);
      pulse_ack();
      parityOdd = 1'b1;
      send_frame(8'h15, 5, 1'b1, 1'b0, 1'b1, 16, -1);
      check("p_odd_ok_perr", 32'(parityErr), 32'h0);
      pulse_ack();
      parityOdd = 1'b0;
      parityEn  = 1'b0;

      // Out-of-range width 0 selects 8 bits; stop bit low
      bitWidth = 4'd0;
      send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0, 16, -1);
      check("fe_dout", 32'(dout), 32'h3C);
      check("fe_ferr", 32'(frameErr), 32'h1);
      check("fe_ready", 32'(rxReady), 32'h1);
      pulse_ack();
      bitWidth = 4'd8;

      // Start glitch of 4 ticks
      repeat (20) @(negedge clk);
      rises_before = rises;
      repeat (4) begin
         @(negedge clk);
         rxd = 1'b0;
      end
      @(negedge clk);
      rxd = 1'b1;
      repeat (30) @(negedge clk);
      check("glitch_ready", 32'(rxReady), 32'h0);
      check("glitch_rises", 32'(rises), 32'(rises_before));
      send_frame(8'h81, 8, 1'b0, 1'b0, 1'b1, 16, -1);
      check("post_glitch_dout", 32'(dout), 32'h81);
      check("post_glitch_rises", 32'(rises), 32'(rises_before + 1));
      pulse_ack();

      // Back-to-back without ack -> overrun
      send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1, 16, -1);
      send_frame(8'h22, 8, 1'b0, 1'b0, 1'b1, 0, -1);
      check("ovr_dout", 32'(dout), 32'h22);
      check("ovr_set", 32'(overrun), 32'h1);
      check("ovr_ready", 32'(rxReady), 32'h1);
      pulse_ack();
      check("ovr_ack_clr", 32'(overrun), 32'h0);
      check("ovr_ack_ready", 32'(rxReady), 32'h0);

      // Ack exactly on second completion (start detect +2, mid-start +8, 9 bits x16)
      send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1, 16, -1);
      send_frame(8'h22, 8, 1'b0, 1'b0, 1'b1, 0, 154);
      check("coinc_ovr", 32'(overrun), 32'h0);
      check("coinc_ready", 32'(rxReady), 32'h1);
      check("coinc_dout", 32'(dout), 32'h22);

      // Reset during data bit 3, then a clean 0x5A
      repeat (16) @(negedge clk);
      for (int c = 0; c < 16 * 4 + 6; c++) begin
         @(negedge clk);
         rxd = frame_bit(8'hF0, 8, 1'b0, 1'b0, 1'b1, c / 16);
      end
      @(negedge clk);
      reset_n = 1'b0;
      rxd     = 1'b1;
      @(negedge clk);
      check("mid_rst_dout", 32'(dout), 32'h0);
      check("mid_rst_ready", 32'(rxReady), 32'h0);
      check("mid_rst_perr", 32'(parityErr), 32'h0);
      check("mid_rst_ferr", 32'(frameErr), 32'h0);
      check("mid_rst_ovr", 32'(overrun), 32'h0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      rises_before = rises;
      send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, 16, -1);
      repeat (40) @(negedge clk);
      check("post_rst_rises", 32'(rises), 32'(rises_before + 1));
      check("post_rst_dout", 32'(dout), 32'h5A);
      check("post_rst_ready", 32'(rxReady), 32'h1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
